fc_seq_ctrl: RTL

//  Sequencer for the fully-connected output stage. On start it walks N_OUT neurons.
//  For each neuron it clears the FP32 MAC, streams N_IN input/weight addresses, and waits for the accumulated sum.
//  It then hands that sum to the 0.5-threshold comparator and collects the 1-bit detect result into detect_vec.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/fc_addr_gen.sv | 71 +++++++
 rtl/fc_seq_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected output-stage sequencer.
// Holds the FP32 word width, the 0.5 threshold constant used by the
// downstream comparator, the sequencer state encoding, and a helper
// that sizes index counters so they never collapse to zero width.
package fc_pkg;

  localparam int FP32_W = 32;
  localparam logic [FP32_W-1:0] FP_HALF = 32'h3F00_0000;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CMP,
    WAIT_CMP,
    DONE
  } state_t;

  // A single-entry range still needs a 1-bit counter.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Address generator for the FC sequencer.
// Keeps the per-neuron input counter and the neuron counter, forms the
// weight address as neuron*N_IN + in_addr, and flags the final MAC term.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start_run     zero the neuron counter at the beginning of a run
//   next_neuron   advance to the next neuron
//   clr_in        zero the input counter (entering CLEAR)
//   feed          high while terms are streamed to the MAC
//   in_addr       input-vector read address
//   w_addr        weight read address
//   neuron        current neuron index
//   in_last       input counter sits on the last term
//   neuron_last   current neuron is the final one of the run
//   mac_last      final-term marker, only while feeding
module fc_addr_gen import fc_pkg::*; #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 4,
  parameter int IN_W  = $clog2(N_IN),
  parameter int W_W   = $clog2(N_IN * N_OUT),
  parameter int NRN_W = idx_w(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_run,
  input  logic             next_neuron,
  input  logic             clr_in,
  input  logic             feed,
  output logic [IN_W-1:0]  in_addr,
  output logic [W_W-1:0]   w_addr,
  output logic [NRN_W-1:0] neuron,
  output logic             in_last,
  output logic             neuron_last,
  output logic             mac_last
);

  localparam logic [W_W-1:0] STRIDE = W_W'(N_IN);

  logic [IN_W-1:0] in_cnt;

  // The input counter stops on the last term so the address is held
  // at its final value until the next CLEAR re-zeroes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (clr_in) begin
      in_cnt <= '0;
    end else if (feed && !in_last) begin
      in_cnt <= in_cnt + IN_W'(1);
    end
  end

  // Neuron index only moves between neurons, so w_addr stays stable
  // through DRAIN/CMP/WAIT_CMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      neuron <= '0;
    end else if (start_run) begin
      neuron <= '0;
    end else if (next_neuron) begin
      neuron <= neuron + NRN_W'(1);
    end
  end

  assign in_addr     = in_cnt;
  assign w_addr      = W_W'(neuron) * STRIDE + W_W'(in_cnt);
  assign in_last     = (in_cnt == IN_W'(N_IN - 1));
  assign neuron_last = (neuron == NRN_W'(N_OUT - 1));
  assign mac_last    = feed && in_last;

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the fully-connected output stage.
// A run walks N_OUT neurons: clear the FP32 MAC, stream N_IN terms, wait
// for the sum, launch the 0.5-threshold comparator with it, and collect
// the detect bit. A wait longer than TIMEOUT cycles on either the MAC or
// the comparator ends the run early with err set.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start / busy / done      run request, run-in-progress, end-of-run pulse
//   err                      sticky timeout flag, cleared by the next start
//   in_addr, w_addr          operand read addresses
//   mac_clr/en/last          MAC control
//   mac_valid, mac_result    MAC sum handshake
//   cmp_data, cmp_valid      comparator launch
//   cmp_valid_out/detect     comparator result
//   detect_vec               per-neuron detect bits
module fc_seq_ctrl import fc_pkg::*; #(
  parameter int N_IN    = 64,
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 256,
  localparam int IN_W   = $clog2(N_IN),
  localparam int W_W    = $clog2(N_IN * N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IN_W-1:0]   in_addr,
  output logic [W_W-1:0]    w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              mac_last,
  input  logic              mac_valid,
  input  logic [FP32_W-1:0] mac_result,
  output logic [FP32_W-1:0] cmp_data,
  output logic              cmp_valid,
  input  logic              cmp_valid_out,
  input  logic              cmp_detect,
  output logic [N_OUT-1:0]  detect_vec
);

  localparam int NRN_W = idx_w(N_OUT);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, next_state;

  logic [CNT_W-1:0] wait_cnt;
  logic [NRN_W-1:0] neuron;
  logic             in_last;
  logic             neuron_last;
  logic             start_run;
  logic             next_neuron;
  logic             clr_in;
  logic             timeout_hit;
  logic             wait_expired;

  fc_addr_gen #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .IN_W  (IN_W),
    .W_W   (W_W),
    .NRN_W (NRN_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .start_run   (start_run),
    .next_neuron (next_neuron),
    .clr_in      (clr_in),
    .feed        (mac_en),
    .in_addr     (in_addr),
    .w_addr      (w_addr),
    .neuron      (neuron),
    .in_last     (in_last),
    .neuron_last (neuron_last),
    .mac_last    (mac_last)
  );

  // Expiry is the last waiting cycle; the response input is checked
  // first so data arriving on that very cycle still wins.
  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the Moore control outputs. Counter controls are
  // raised on the transition into CLEAR so in_addr already reads 0 there.
  always_comb begin
    next_state  = state;
    start_run   = 1'b0;
    next_neuron = 1'b0;
    clr_in      = 1'b0;
    timeout_hit = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    mac_clr     = (state == CLEAR);
    mac_en      = (state == FEED);
    cmp_valid   = (state == CMP);
    case (state)
      IDLE: begin
        if (start) begin
          next_state = CLEAR;
          start_run  = 1'b1;
          clr_in     = 1'b1;
        end
      end
      CLEAR: next_state = FEED;
      FEED: begin
        if (in_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (mac_valid) begin
          next_state = CMP;
        end else if (wait_expired) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
      end
      CMP: next_state = WAIT_CMP;
      WAIT_CMP: begin
        if (cmp_valid_out) begin
          if (neuron_last) begin
            next_state = DONE;
          end else begin
            next_state  = CLEAR;
            next_neuron = 1'b1;
            clr_in      = 1'b1;
          end
        end else if (wait_expired) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Wait counter runs only while staying in a waiting state, so it is
  // back at zero on every entry into DRAIN or WAIT_CMP.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (((state == DRAIN) || (state == WAIT_CMP)) && (next_state == state)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag, cleared when a new run is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_run) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end

  // The MAC sum is captured once and held for the comparator until its
  // result returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_data <= '0;
    end else if ((state == DRAIN) && mac_valid) begin
      cmp_data <= mac_result;
    end
  end

  // Detect bits are cleared per run; neurons skipped by a timeout keep 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      detect_vec <= '0;
    end else if (start_run) begin
      detect_vec <= '0;
    end else if ((state == WAIT_CMP) && cmp_valid_out) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (neuron == NRN_W'(i)) begin
          detect_vec[i] <= cmp_detect;
        end
      end
    end
  end

endmodule
